// File: rtl/key_debounce_bank.sv
// rtl/key_debounce_bank.sv - multi-channel key synchroniser, tick-based debouncer and edge pulser
// Optional auto-repeat on held keys is enabled by defining KEY_REPEAT_EN.
module key_debounce_bank #(
    parameter int NKEYS        = 18,
    parameter int SAMPLE_DIV   = 50000,
    parameter int STABLE_CNT   = 8,
    parameter int ACTIVE_LOW   = 0,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NKEYS-1:0] key_in,
    output logic [NKEYS-1:0] key_state,
    output logic [NKEYS-1:0] key_press,
    output logic [NKEYS-1:0] key_release,
    output logic             sample_tick
);

    localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam logic [PW-1:0] DIV_LAST = PW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);
    localparam logic [NKEYS-1:0] IDLE_LEVEL = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [PW-1:0]    div_cnt;
    logic [NKEYS-1:0] sync1;
    logic [NKEYS-1:0] sync2;
    logic [NKEYS-1:0] level;
    logic [CW-1:0]    cnt [NKEYS];

`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_WRAP  = RW'(REPEAT_DELAY + REPEAT_RATE);
    logic [RW-1:0] rep [NKEYS];
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = REPEAT_DELAY[0] ^ REPEAT_RATE[0];
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_cnt     <= '0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= (div_cnt == DIV_LAST);
            div_cnt     <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    // Sync flops idle at the released level so reset never looks like a press.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= IDLE_LEVEL;
            sync2 <= IDLE_LEVEL;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    assign level = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            key_state   <= '0;
            key_press   <= '0;
            key_release <= '0;
            for (int i = 0; i < NKEYS; i++) begin
                cnt[i] <= '0;
`ifdef KEY_REPEAT_EN
                rep[i] <= '0;
`endif
            end
        end else begin
            key_press   <= '0;
            key_release <= '0;
            if (sample_tick) begin
                for (int i = 0; i < NKEYS; i++) begin
                    if (level[i] == key_state[i]) begin
                        cnt[i] <= '0;
`ifdef KEY_REPEAT_EN
                        // Held key: first repeat at REPEAT_DELAY, then fold back every REPEAT_RATE.
                        if (key_state[i]) begin
                            if (rep[i] == REP_WRAP - 1'b1) begin
                                rep[i]       <= REP_FIRST;
                                key_press[i] <= 1'b1;
                            end else begin
                                rep[i] <= rep[i] + 1'b1;
                                if (rep[i] == REP_FIRST - 1'b1)
                                    key_press[i] <= 1'b1;
                            end
                        end
`endif
                    end else if (cnt[i] == CNT_LAST) begin
                        key_state[i]   <= level[i];
                        cnt[i]         <= '0;
                        key_press[i]   <= level[i];
                        key_release[i] <= ~level[i];
`ifdef KEY_REPEAT_EN
                        rep[i]         <= '0;
`endif
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule
